// File: rtl/spi_slave_regif.sv
// SPI slave register-interface front end: oversamples the SPI pins in the clk domain and turns each
// 16-bit command/data transaction into single-cycle register strobes. Define SPI_SLAVE_XFERERR_EN for xfer_err.
module spi_slave_regif (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       ssn,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       xfer_err
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, DONE, OVER} state_t;
  state_t state, state_nx;

  // [0] metastable stage, [1] synced value, [2] delayed copy for edge detect
  logic [2:0] sclk_sy;
  logic [2:0] ssn_sy;
  logic [1:0] mosi_sy;

  logic       ssn_s, mosi_s, rise, ssn_fall, active, step;
  logic [4:0] cnt;
  logic [6:0] sr;
  logic       rw;
  logic [7:0] hold;
  logic [7:0] mshift;
  logic       rd_d1;
  logic       cap_addr, rd_go, load_miso, wr_go;

  // ssn flops reset low so a transaction already running at reset release shows no ssn fall
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sy <= 3'b111;
      ssn_sy  <= 3'b000;
      mosi_sy <= 2'b00;
    end else begin
      sclk_sy <= {sclk_sy[1:0], sclk};
      ssn_sy  <= {ssn_sy[1:0], ssn};
      mosi_sy <= {mosi_sy[0], mosi};
    end
  end

  assign ssn_s    = ssn_sy[1];
  assign mosi_s   = mosi_sy[1];
  assign rise     = sclk_sy[1] & ~sclk_sy[2];
  assign ssn_fall = ~ssn_sy[1] & ssn_sy[2];
  assign active   = (state != IDLE);
  assign step     = rise & active & ~ssn_s;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ssn_fall) state_nx = CMD;
      CMD:     if (step && cnt == 5'd7) state_nx = DATA;
      DATA:    if (step && cnt == 5'd15) state_nx = DONE;
      DONE:    if (step) state_nx = OVER;
      OVER:    state_nx = OVER;
      default: state_nx = IDLE;
    endcase
    if (active && ssn_s) state_nx = IDLE;
  end

  // The shift register holds the previous bits; the bit arriving with the current rise is mosi_s.
  always_comb begin
    cap_addr  = (state == CMD) && step && (cnt == 5'd4);
    rd_go     = cap_addr && sr[3];
    load_miso = (state == CMD) && step && (cnt == 5'd7) && rw;
    wr_go     = (state == DATA) && step && (cnt == 5'd15) && !rw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      sr        <= '0;
      rw        <= 1'b0;
      hold      <= '0;
      mshift    <= '0;
      rd_d1     <= 1'b0;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      reg_rd <= rd_go;
      rd_d1  <= reg_rd;
      reg_wr <= wr_go;
      if (rd_d1)    hold <= reg_rdata;
      if (cap_addr) begin
        reg_addr <= {sr[2:0], mosi_s};
        rw       <= sr[3];
      end
      if (wr_go) reg_wdata <= {sr[6:0], mosi_s};
      if (!active || ssn_s) begin
        cnt    <= '0;
        sr     <= '0;
        mshift <= '0;
      end else if (step) begin
        sr <= {sr[5:0], mosi_s};
        if (cnt != 5'd17) cnt <= cnt + 5'd1;
        if (load_miso) mshift <= hold;
        else           mshift <= {mshift[6:0], 1'b0};
      end
    end
  end

  assign miso    = mshift[7];
  assign miso_oe = ~ssn_s & (active | ssn_fall);

`ifdef SPI_SLAVE_XFERERR_EN
  logic ssn_rise;
  assign ssn_rise = ssn_sy[1] & ~ssn_sy[2];

  always_ff @(posedge clk) begin
    if (reset) xfer_err <= 1'b0;
    else       xfer_err <= active && ssn_rise && (cnt != 5'd0) && (cnt != 5'd16);
  end
`else
  assign xfer_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_regif.sv
// Bench for spi_slave_regif: bit-banged SPI master, register-file responder, table vectors,
// a mid-transaction reset sequence and randomized transactions against a transaction-level model.
module tb_spi_slave_regif;

`ifdef SPI_SLAVE_XFERERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, sclk, ssn, mosi;
  logic       miso, miso_oe, reg_wr, reg_rd, xfer_err;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  spi_slave_regif dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ssn(ssn), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata), .xfer_err(xfer_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    int         nbits;
    bit         exp_rd;
    bit         exp_wr;
    logic [7:0] exp_rx;
    bit         exp_err;
  } vec_t;

  int tests  = 0;
  int failed = 0;

  function automatic logic [7:0] init_val(input int i);
    return (i == 13) ? 8'h30 : 8'((i * 37 + 11) & 255);
  endfunction

  // register-file responder: combinational read, writes land on reg_wr
  logic [7:0] resp_mem [16];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 16; i++) resp_mem[i] <= init_val(i);
    else if (reg_wr) resp_mem[reg_addr] <= reg_wdata;
  end
  assign reg_rdata = resp_mem[reg_addr];

  // strobe monitor
  int         rd_cnt = 0, wr_cnt = 0, err_cnt = 0;
  logic [3:0] last_rd_addr, last_wr_addr;
  logic [7:0] last_wdata;
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_rd) begin rd_cnt++; last_rd_addr = reg_addr; end
      if (reg_wr) begin wr_cnt++; last_wr_addr = reg_addr; last_wdata = reg_wdata; end
      if (xfer_err) err_cnt++;
    end
  end

  logic [7:0] model_mem [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_begin;
    ssn = 1'b0;
    tick(4);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    sclk = 1'b0;
    mosi = b;
    tick(4);
    r = miso;
    sclk = 1'b1;
    tick(4);
  endtask

  task automatic spi_end;
    tick(4);
    ssn  = 1'b1;
    mosi = 1'b0;
    tick(8);
  endtask

  // transaction-level expectation from the command/data/bit-count rules
  function automatic vec_t make_vec(input logic [7:0] cmd, input logic [7:0] data, input int nbits);
    vec_t v;
    v.cmd     = cmd;
    v.data    = data;
    v.nbits   = nbits;
    v.exp_rd  = cmd[7] && nbits >= 5;
    v.exp_wr  = !cmd[7] && nbits >= 16;
    v.exp_rx  = cmd[7] ? model_mem[cmd[6:3]] : 8'h00;
    v.exp_err = ERR_EN && nbits != 0 && nbits != 16;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] tx;
    logic [17:0] rx, ex;
    logic        r, b;
    int          rd0, wr0, err0;
    logic [3:0]  addr;
    tx   = {v.cmd, v.data};
    addr = v.cmd[6:3];
    rx   = '0;
    ex   = '0;
    rd0  = rd_cnt; wr0 = wr_cnt; err0 = err_cnt;
    spi_begin();
    for (int i = 0; i < v.nbits; i++) begin
      b = (i < 16) ? tx[15 - i] : 1'($urandom);
      spi_bit(b, r);
      rx[i] = r;
    end
    if (v.nbits > 0) check($sformatf("%s miso_oe_active", tag), 32'(miso_oe), 32'd1);
    for (int i = 8; i < v.nbits && i < 16; i++) ex[i] = v.exp_rx[15 - i];
    spi_end();
    check($sformatf("%s rd_count", tag), 32'(rd_cnt - rd0), 32'(v.exp_rd));
    check($sformatf("%s wr_count", tag), 32'(wr_cnt - wr0), 32'(v.exp_wr));
    check($sformatf("%s err_count", tag), 32'(err_cnt - err0), 32'(v.exp_err));
    check($sformatf("%s miso_bits", tag), 32'(rx), 32'(ex));
    check($sformatf("%s miso_oe_idle", tag), 32'(miso_oe), 32'd0);
    if (v.exp_rd) check($sformatf("%s rd_addr", tag), 32'(last_rd_addr), 32'(addr));
    if (v.exp_wr) begin
      check($sformatf("%s wr_addr", tag), 32'(last_wr_addr), 32'(addr));
      check($sformatf("%s wr_data", tag), 32'(last_wdata), 32'(v.data));
      model_mem[addr] = v.data;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s miso", tag), 32'(miso), 32'd0);
    check($sformatf("%s miso_oe", tag), 32'(miso_oe), 32'd0);
    check($sformatf("%s reg_addr", tag), 32'(reg_addr), 32'd0);
    check($sformatf("%s reg_wdata", tag), 32'(reg_wdata), 32'd0);
    check($sformatf("%s reg_wr", tag), 32'(reg_wr), 32'd0);
    check($sformatf("%s reg_rd", tag), 32'(reg_rd), 32'd0);
    check($sformatf("%s xfer_err", tag), 32'(xfer_err), 32'd0);
  endtask

  vec_t tbl [7];

  initial begin
    logic        r;
    logic [15:0] tx;
    logic [6:0]  tail;
    int          rd0, wr0, err0, sel, nb;

    tbl[0] = '{8'hE8, 8'h00, 16, 1'b1, 1'b0, 8'h30, 1'b0};
    tbl[1] = '{8'h10, 8'h01, 16, 1'b0, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{8'h30, 8'h02, 16, 1'b0, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{8'hB0, 8'h00, 16, 1'b1, 1'b0, 8'h02, 1'b0};
    tbl[4] = '{8'h10, 8'hA7, 10, 1'b0, 1'b0, 8'h00, ERR_EN};
    tbl[5] = '{8'hE8, 8'h00, 16, 1'b1, 1'b0, 8'h30, 1'b0};
    tbl[6] = '{8'h18, 8'h55, 17, 1'b0, 1'b1, 8'h00, ERR_EN};

    for (int i = 0; i < 16; i++) model_mem[i] = init_val(i);

    // clock/reset
    reset = 1'b1; sclk = 1'b1; ssn = 1'b1; mosi = 1'b0; mem_init = 1'b1;
    tick(3);
    mem_init = 1'b0;
    check_reset_outputs("reset");
    reset = 1'b0;
    tick(6);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // reset while the 9th bit of a read to 0xF is in flight
    tx = 16'hF800;
    spi_begin();
    for (int i = 0; i < 9; i++) spi_bit(tx[15 - i], r);
    reset = 1'b1;
    tick(3);
    check_reset_outputs("midreset");
    reset = 1'b0;
    rd0 = rd_cnt; wr0 = wr_cnt; err0 = err_cnt;
    for (int i = 9; i < 16; i++) begin
      spi_bit(tx[15 - i], r);
      tail[i - 9] = r;
    end
    spi_end();
    check("midreset tail_miso", 32'(tail), 32'd0);
    check("midreset tail_rd", 32'(rd_cnt - rd0), 32'd0);
    check("midreset tail_wr", 32'(wr_cnt - wr0), 32'd0);
    check("midreset tail_err", 32'(err_cnt - err0), 32'd0);
    run_vec(make_vec(8'hF8, 8'h00, 16), "read_f");

    // randomized transactions
    for (int k = 0; k < 24; k++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      nb = 16;
      else if (sel <= 7) nb = $urandom_range(0, 15);
      else               nb = $urandom_range(17, 18);
      run_vec(make_vec(8'($urandom), 8'($urandom), nb), $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
